// File: rtl/decoder3x8_pipe_pkg.sv
// decoder3x8_pipe_pkg
// Shared definitions for the pipelined 3-to-8 decoder:
//   CODE_W   - width of a binary line index
//   ONEHOT_W - width of the decoded one-hot word
//   state_e  - occupancy FSM encoding of the 2-entry buffer
package decoder3x8_pipe_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 1 << CODE_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/decoder3x8_pipe_dec3to8.sv
// dec3to8
// Pure combinational binary-to-one-hot decoder.
// Ports:
//   i_code   - binary line index
//   o_onehot - one-hot word with bit i_code set
module dec3to8
  import decoder3x8_pipe_pkg::*;
(
  input  logic [CODE_W-1:0]   i_code,
  output logic [ONEHOT_W-1:0] o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/decoder3x8_pipe.sv
// decoder3x8_pipe
// Buffers 3-bit codes in a 2-entry FIFO and presents the head entry both as
// a binary code and as a one-hot word. Counts delivered words (saturating)
// and keeps a sticky OR of every delivered one-hot word.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. in_ready depends on registered state only, and
// out_* are stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous flush of buffer, counter and sticky map
//   in_code/in_valid/in_ready       - upstream interface
//   out_onehot/out_code/out_valid/out_ready - downstream interface
//   word_cnt    - saturating count of delivered words
//   seen        - sticky OR of delivered one-hot words
//   dbg_state   - current occupancy FSM state
module decoder3x8_pipe
  import decoder3x8_pipe_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    word_cnt,
  output logic [ONEHOT_W-1:0] seen,
  output logic [1:0]          dbg_state
);

  state_e                r_state;
  state_e                w_next_state;
  logic [CODE_W-1:0]     r_e0;  // head entry
  logic [CODE_W-1:0]     r_e1;  // second entry, only meaningful in ST_FULL
  logic [CNT_W-1:0]      r_word_cnt;
  logic [ONEHOT_W-1:0]   r_seen;
  logic                  w_push;
  logic                  w_pop;
  logic [ONEHOT_W-1:0]   w_head_onehot;

  assign w_push = in_valid && (r_state != ST_FULL);
  assign w_pop  = out_ready && (r_state != ST_EMPTY);

  // Next-state logic; clr overrides any push/pop.
  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_next_state = ST_FULL;
          else if (!w_push && w_pop) w_next_state = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  // Entry storage carries no reset: outputs are masked by state instead.
  always_ff @(posedge clk) begin
    if (!clr) begin
      case (r_state)
        ST_EMPTY: if (w_push) r_e0 <= in_code;
        ST_ONE: begin
          if (w_push && w_pop) r_e0 <= in_code;
          else if (w_push)     r_e1 <= in_code;
        end
        ST_FULL:  if (w_pop) r_e0 <= r_e1;
        default: ;
      endcase
    end
  end

  dec3to8 u_dec3to8 (
    .i_code   (r_e0),
    .o_onehot (w_head_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_seen     <= '0;
    end else if (clr) begin
      r_word_cnt <= '0;
      r_seen     <= '0;
    end else if (w_pop) begin
      if (r_word_cnt != {CNT_W{1'b1}}) r_word_cnt <= r_word_cnt + CNT_W'(1);
      r_seen <= r_seen | w_head_onehot;
    end
  end

  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_code   = out_valid ? r_e0 : '0;
  assign out_onehot = out_valid ? w_head_onehot : '0;
  assign word_cnt   = r_word_cnt;
  assign seen       = r_seen;
  assign dbg_state  = r_state;

endmodule
